// File: rtl/haze_ctrl_pkg.sv
// haze_ctrl_pkg: state encoding and pixel-count helper shared by the haze pass sequencer.
// Rev 1.0
`default_nettype none

package haze_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ALE_PASS  = 3'd1;
  localparam logic [2:0] ST_ALE_WAIT  = 3'd2;
  localparam logic [2:0] ST_SRSC_PASS = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  function automatic int unsigned pix_count(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

`default_nettype wire

// File: rtl/beat_counter.sv
// beat_counter: up-counter with synchronous clear, increment enable and saturation at MAX.
// Rev 1.0
`default_nettype none

module beat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear has priority so a pass entry never inherits a stray beat.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < MAX_C)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/haze_pass_sequencer.sv
// haze_pass_sequencer: two-pass frame controller (ALE pass, then transmission/recovery pass)
// gating the upstream DMA stream into the haze core. Rev 1.0
`default_nettype none

module haze_pass_sequencer
  import haze_ctrl_pkg::*;
#(
  parameter int IMG_W       = 512,
  parameter int IMG_H       = 512,
  parameter int OUT_PIXELS  = 260100,
  parameter int ALE_TIMEOUT = 4096,
  parameter int CNT_W       = $clog2(IMG_W * IMG_H + 1)
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic start,
  input  logic skip_ale,
  input  logic up_tvalid,
  input  logic up_tlast,
  output logic up_tready,
  output logic core_s_tvalid,
  input  logic core_s_tready,
  input  logic core_m_tvalid,
  output logic m_tlast,
  input  logic ale_done,
  output logic haze_enable,
  output logic busy,
  output logic frame_done,
  output logic timeout_err,
  output logic tlast_err
);

  localparam int PIX   = int'(pix_count(IMG_W, IMG_H));
  localparam int TMR_W = $clog2(ALE_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] PIX_C    = CNT_W'(PIX);
  localparam logic [CNT_W-1:0] PIX_M1   = CNT_W'(PIX - 1);
  localparam logic [CNT_W-1:0] OUT_C    = CNT_W'(OUT_PIXELS);
  localparam logic [CNT_W-1:0] OUT_M1   = CNT_W'(OUT_PIXELS - 1);
  localparam logic [TMR_W-1:0] TMO_M1   = TMR_W'(ALE_TIMEOUT - 1);

  state_t state_q, state_d;
  logic   a_valid_q, a_valid_d;
  logic   ale_seen_q, ale_seen_d;
  logic   haze_q, haze_d;
  logic   fdone_q, fdone_d;
  logic   terr_q, terr_d;
  logic   lerr_q, lerr_d;

  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [TMR_W-1:0] tmr;

  logic in_pass, out_phase, gate, accept, last_in, tmr_exp, state_chg;

  assign in_pass   = (state_q == ST_ALE_PASS) || (state_q == ST_SRSC_PASS);
  assign out_phase = (state_q == ST_SRSC_PASS) || (state_q == ST_DRAIN);
  assign gate      = in_pass && (in_cnt < PIX_C);

  assign up_tready     = core_s_tready & gate;
  assign core_s_tvalid = up_tvalid & gate;
  assign accept        = up_tvalid & up_tready;
  assign last_in       = accept && (in_cnt == PIX_M1);
  assign tmr_exp       = (tmr == TMO_M1);

  assign m_tlast = core_m_tvalid && out_phase && (out_cnt == OUT_M1);

  always_comb begin
    state_d    = state_q;
    a_valid_d  = a_valid_q;
    ale_seen_d = ale_seen_q;
    terr_d     = terr_q;
    lerr_d     = lerr_q;
    fdone_d    = 1'b0;

    // Beat count is authoritative; a misplaced TLAST only flags the error.
    if (accept && (up_tlast != (in_cnt == PIX_M1))) begin
      lerr_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          terr_d  = 1'b0;
          lerr_d  = 1'b0;
          state_d = (skip_ale && a_valid_q) ? ST_SRSC_PASS : ST_ALE_PASS;
        end
      end
      ST_ALE_PASS: begin
        if (ale_done) begin
          ale_seen_d = 1'b1;
        end
        if (last_in) begin
          state_d = ST_ALE_WAIT;
        end
      end
      ST_ALE_WAIT: begin
        if (ale_done || ale_seen_q) begin
          a_valid_d  = 1'b1;
          ale_seen_d = 1'b0;
          state_d    = ST_SRSC_PASS;
        end else if (tmr_exp) begin
          terr_d  = 1'b1;
          fdone_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SRSC_PASS: begin
        if (last_in) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_cnt == OUT_C) begin
          state_d = ST_DONE;
        end else if (tmr_exp) begin
          terr_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_DONE) begin
      fdone_d = 1'b1;
    end
    haze_d = (state_d == ST_SRSC_PASS) || (state_d == ST_DRAIN);
  end

  assign state_chg = (state_d != state_q);

  beat_counter #(.WIDTH(CNT_W), .MAX(PIX)) u_in_cnt (
    .clk_i  (ACLK),
    .rst_ni (ARESETn),
    .clr_i  (state_chg && ((state_d == ST_ALE_PASS) || (state_d == ST_SRSC_PASS))),
    .inc_i  (accept),
    .cnt_o  (in_cnt)
  );

  beat_counter #(.WIDTH(CNT_W), .MAX(OUT_PIXELS)) u_out_cnt (
    .clk_i  (ACLK),
    .rst_ni (ARESETn),
    .clr_i  (state_chg && (state_d == ST_SRSC_PASS)),
    .inc_i  (core_m_tvalid && out_phase),
    .cnt_o  (out_cnt)
  );

  beat_counter #(.WIDTH(TMR_W), .MAX(ALE_TIMEOUT)) u_timer (
    .clk_i  (ACLK),
    .rst_ni (ARESETn),
    .clr_i  (state_chg),
    .inc_i  ((state_q == ST_ALE_WAIT) || (state_q == ST_DRAIN)),
    .cnt_o  (tmr)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      a_valid_q  <= 1'b0;
      ale_seen_q <= 1'b0;
      haze_q     <= 1'b0;
      fdone_q    <= 1'b0;
      terr_q     <= 1'b0;
      lerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_valid_q  <= a_valid_d;
      ale_seen_q <= ale_seen_d;
      haze_q     <= haze_d;
      fdone_q    <= fdone_d;
      terr_q     <= terr_d;
      lerr_q     <= lerr_d;
    end
  end

  assign haze_enable = haze_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = fdone_q;
  assign timeout_err = terr_q;
  assign tlast_err   = lerr_q;

endmodule

`default_nettype wire

// File: tb/tb_haze_pass_sequencer.sv
// tb_haze_pass_sequencer: directed frames on a 4x4 image, checked every cycle against a frame-level model.
// Rev 1.0
`default_nettype none

module tb_haze_pass_sequencer;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int PIX  = W * H;
  localparam int OUTP = 4;
  localparam int TO   = 8;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic start = 1'b0, skip_ale = 1'b0;
  logic up_tvalid = 1'b0, up_tlast = 1'b0;
  logic core_s_tready = 1'b1, core_m_tvalid = 1'b0, ale_done = 1'b0;
  logic up_tready, core_s_tvalid, m_tlast, haze_enable, busy, frame_done, timeout_err, tlast_err;

  int n_chk = 0;
  int n_fail = 0;
  int tlast_seen = 0;
  int fd_seen = 0;

  always #5 ACLK = ~ACLK;

  haze_pass_sequencer #(
    .IMG_W(W), .IMG_H(H), .OUT_PIXELS(OUTP), .ALE_TIMEOUT(TO)
  ) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .start         (start),
    .skip_ale      (skip_ale),
    .up_tvalid     (up_tvalid),
    .up_tlast      (up_tlast),
    .up_tready     (up_tready),
    .core_s_tvalid (core_s_tvalid),
    .core_s_tready (core_s_tready),
    .core_m_tvalid (core_m_tvalid),
    .m_tlast       (m_tlast),
    .ale_done      (ale_done),
    .haze_enable   (haze_enable),
    .busy          (busy),
    .frame_done    (frame_done),
    .timeout_err   (timeout_err),
    .tlast_err     (tlast_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: phase 0 idle, 1 ALE input, 2 waiting for ALE, 3 recovery input, 4 drain, 5 done
  int ph = 0, m_in = 0, m_out = 0, m_wait = 0;
  bit m_av = 0, m_seen = 0, m_terr = 0, m_lerr = 0, m_fd = 0;

  function automatic bit mgate();
    return ((ph == 1) || (ph == 3)) && (m_in < PIX);
  endfunction

  always @(posedge ACLK or negedge ARESETn) begin : model
    bit acc;
    if (!ARESETn) begin
      ph = 0; m_in = 0; m_out = 0; m_wait = 0;
      m_av = 0; m_seen = 0; m_terr = 0; m_lerr = 0; m_fd = 0;
    end else begin
      acc  = up_tvalid && core_s_tready && mgate();
      m_fd = 0;
      if (acc && (up_tlast != (m_in == PIX - 1))) m_lerr = 1;
      case (ph)
        0: if (start) begin
          m_terr = 0; m_lerr = 0; m_in = 0;
          if (skip_ale && m_av) begin ph = 3; m_out = 0; end
          else ph = 1;
        end
        1: begin
          if (ale_done) m_seen = 1;
          if (acc) m_in++;
          if (m_in == PIX) begin ph = 2; m_wait = 0; end
        end
        2: begin
          if (ale_done || m_seen) begin
            m_av = 1; m_seen = 0; ph = 3; m_in = 0; m_out = 0;
          end else begin
            m_wait++;
            if (m_wait == TO) begin m_terr = 1; m_fd = 1; ph = 0; end
          end
        end
        3: begin
          if (core_m_tvalid && (m_out < OUTP)) m_out++;
          if (acc) m_in++;
          if (m_in == PIX) begin ph = 4; m_wait = 0; end
        end
        4: begin
          if (m_out == OUTP) ph = 5;
          else begin
            if (core_m_tvalid) m_out++;
            m_wait++;
            if (m_wait == TO) begin m_terr = 1; ph = 5; end
          end
        end
        default: ph = 0;
      endcase
      if (ph == 5) m_fd = 1;
    end
  end

  always @(negedge ACLK) begin : compare
    bit g;
    g = mgate();
    chk("up_tready",     up_tready,     core_s_tready && g);
    chk("core_s_tvalid", core_s_tvalid, up_tvalid && g);
    chk("m_tlast",       m_tlast,       core_m_tvalid && (ph == 3 || ph == 4) && (m_out == OUTP - 1));
    chk("haze_enable",   haze_enable,   (ph == 3 || ph == 4));
    chk("busy",          busy,          (ph != 0));
    chk("frame_done",    frame_done,    m_fd);
    chk("timeout_err",   timeout_err,   m_terr);
    chk("tlast_err",     tlast_err,     m_lerr);
    if (m_tlast === 1'b1) tlast_seen++;
    if (frame_done === 1'b1) fd_seen++;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic pulse_start(input logic skip);
    start = 1'b1; skip_ale = skip;
    tick();
    start = 1'b0; skip_ale = 1'b0;
  endtask

  // Offers n beats; tl_at / ale_k / out_from are beat indices (-1 or past n disables).
  task automatic send(input string nm, input int n, input int tl_at, input bit gaps,
                      input bit bp, input int out_from, input int ale_k);
    int k = 0;
    int cyc = 0;
    while ((k < n) && (cyc < 200)) begin
      up_tvalid     = !(gaps && (cyc % 3 == 2));
      up_tlast      = (k == tl_at);
      core_s_tready = !(bp && (cyc % 2 == 1));
      core_m_tvalid = (k >= out_from);
      ale_done      = (k == ale_k);
      @(negedge ACLK);
      if (up_tvalid && up_tready) k++;
      tick();
      cyc++;
    end
    up_tvalid = 1'b0; up_tlast = 1'b0; core_s_tready = 1'b1;
    core_m_tvalid = 1'b0; ale_done = 1'b0;
    chk(nm, k, n);
  endtask

  task automatic drive_out(input int n);
    for (int i = 0; i < n + 1; i++) begin
      core_m_tvalid = (i != 2);
      tick();
    end
    core_m_tvalid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int c = 0;
    bit got = 0;
    while ((c < 40) && !got) begin
      @(negedge ACLK);
      if (frame_done) got = 1;
      tick();
      c++;
    end
    chk(nm, got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    ARESETn = 1'b1;
    tick();
    @(negedge ACLK);
    chk("rst_busy", busy, 0);
    chk("rst_haze", haze_enable, 0);
    chk("rst_errs", {timeout_err, tlast_err, frame_done}, 0);
    tick();

    // Nominal frame: two passes, outputs overlap the last four pass-2 beats
    tlast_seen = 0; fd_seen = 0;
    pulse_start(1'b0);
    send("s1_p1_beats", PIX, PIX - 1, 1'b0, 1'b0, 99, -1);
    tick(); tick();
    ale_done = 1'b1; tick(); ale_done = 1'b0;
    @(negedge ACLK);
    chk("s1_haze_p2", haze_enable, 1);
    tick();
    send("s1_p2_beats", PIX, PIX - 1, 1'b0, 1'b0, PIX - 4, -1);
    wait_done("s1_done");
    chk("s1_tlast_cnt", tlast_seen, 1);
    chk("s1_fd_cnt", fd_seen, 1);
    chk("s1_errs", {timeout_err, tlast_err}, 0);

    // Reuse latched atmospheric light
    pulse_start(1'b1);
    @(negedge ACLK);
    chk("s2_haze_first", haze_enable, 1);
    tick();
    send("s2_beats", PIX, PIX - 1, 1'b0, 1'b0, 99, -1);
    drive_out(OUTP);
    wait_done("s2_done");

    // Backpressure and gaps; ale_done arrives with the last pass-1 beat
    pulse_start(1'b0);
    send("s4_p1_beats", PIX, PIX - 1, 1'b1, 1'b1, 99, PIX - 1);
    send("s4_p2_beats", PIX, PIX - 1, 1'b1, 1'b1, 99, -1);
    drive_out(OUTP);
    wait_done("s4_done");
    chk("s4_terr", timeout_err, 0);

    // TLAST on beat 5
    pulse_start(1'b1);
    send("s5_beats", PIX, 4, 1'b0, 1'b0, 99, -1);
    drive_out(OUTP);
    wait_done("s5_done");
    chk("s5_lerr", tlast_err, 1);
    chk("s5_terr", timeout_err, 0);

    // Reset clears a_valid, then an ALE timeout
    ARESETn = 1'b0; tick(); tick(); ARESETn = 1'b1; tick();
    pulse_start(1'b1);
    @(negedge ACLK);
    chk("s3_skip_ignored", {busy, haze_enable}, 2'b10);
    tick();
    send("s3_beats", PIX, PIX - 1, 1'b0, 1'b0, 99, -1);
    wait_done("s3_done");
    chk("s3_terr", timeout_err, 1);
    chk("s3_idle", busy, 0);
    pulse_start(1'b1);
    @(negedge ACLK);
    chk("s3_still_ale", {busy, haze_enable, timeout_err}, 3'b100);
    tick();

    // Asynchronous reset mid recovery pass
    send("s6_p1_beats", PIX, PIX - 1, 1'b0, 1'b0, 99, PIX - 1);
    send("s6_part_beats", 5, -1, 1'b0, 1'b0, 99, -1);
    up_tvalid = 1'b1;
    #2 ARESETn = 1'b0;
    #1;
    chk("s6_rst_gate", {up_tready, core_s_tvalid}, 0);
    chk("s6_rst_state", {haze_enable, busy, frame_done}, 0);
    up_tvalid = 1'b0;
    tick();
    ARESETn = 1'b1;
    tick();
    pulse_start(1'b1);
    @(negedge ACLK);
    chk("s6_new_pass1", {busy, haze_enable}, 2'b10);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/haze_pass_sequencer.md
Name: haze_pass_sequencer

Overview:
Frame-level controller in front of the haze-removal core. It runs each frame as two passes over the same image. Pass 1 feeds the atmospheric-light estimator (core enable=0). Pass 2 feeds transmission estimation and scene recovery (core enable=1). It gates the upstream DMA stream into the core, counts accepted input beats and produced output beats, generates output TLAST, and reports done, timeout and framing errors.

Parameters:
IMG_W, 512, image width in pixels
IMG_H, 512, image height in pixels
OUT_PIXELS, 260100, output beats expected per pass 2, equal to (IMG_W-2)*(IMG_H-2)
ALE_TIMEOUT, 4096, cycles allowed for ale_done after pass 1 input ends, and for the pass 2 drain
CNT_W, $clog2(IMG_W*IMG_H+1), width of the beat counters

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a frame
skip_ale  in  1  sampled with start; reuses the latched atmospheric light
up_tvalid  in  1  upstream DMA valid
up_tlast  in  1  upstream DMA last
up_tready  out  1  ready to upstream DMA
core_s_tvalid  out  1  valid into the core slave port
core_s_tready  in  1  core slave ready
core_m_tvalid  in  1  core output valid (the core does not apply backpressure)
m_tlast  out  1  TLAST for the core output stream
ale_done  in  1  ALE done pulse from the core
haze_enable  out  1  drives the core enable input
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at the end of a frame
timeout_err  out  1  sticky; set on an ALE or drain timeout
tlast_err  out  1  sticky; set on upstream TLAST misplacement

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; a_valid 0; ale_seen 0. Reset is asynchronous and can occur in any state; the block returns to IDLE with no residual gating.
- States (in package):
  - IDLE:
    - On start, clear both sticky errors.
    - If skip_ale=1 and a_valid=1, go to SRSC_PASS on the next edge.
    - Otherwise go to ALE_PASS.
    - start in any other state is ignored.
  - ALE_PASS:
    - haze_enable=0.
    - Accept beats until in_cnt reaches IMG_W*IMG_H, then go to ALE_WAIT.
    - ale_done arriving in this state sets ale_seen.
  - ALE_WAIT:
    - Leave on ale_done or ale_seen: set a_valid, clear ale_seen, go to SRSC_PASS.
    - The timer counts to ALE_TIMEOUT. On expiry: set timeout_err, pulse frame_done, go to IDLE, leave a_valid unchanged.
  - SRSC_PASS:
    - haze_enable=1, registered so it is high from the first cycle in this state.
    - Accept IMG_W*IMG_H beats, then go to DRAIN.
    - Output beats are counted here as well.
  - DRAIN:
    - haze_enable=1.
    - Wait until out_cnt reaches OUT_PIXELS, then go to DONE.
    - The timer counts to ALE_TIMEOUT. On expiry: set timeout_err, go to DONE.
  - DONE: one cycle; frame_done=1; haze_enable returns to 0; go to IDLE.
- Gating (combinational):
  - gate = (state==ALE_PASS or state==SRSC_PASS) and in_cnt < IMG_W*IMG_H.
  - up_tready = core_s_tready and gate.
  - core_s_tvalid = up_tvalid and gate.
  - A beat is accepted when up_tvalid and up_tready are both high.
- Counters:
  - in_cnt resets to 0 on entry to each pass and increments on every accepted beat.
  - out_cnt resets on entry to SRSC_PASS, increments on core_m_tvalid in SRSC_PASS/DRAIN, and saturates at OUT_PIXELS.
  - core_m_tvalid outside SRSC_PASS/DRAIN is not counted.
- m_tlast = core_m_tvalid and (state is SRSC_PASS or DRAIN) and out_cnt==OUT_PIXELS-1. Combinational, aligned with the core TDATA.
- tlast_err is set in either of two cases:
  - Accepted beat with up_tlast=1 and in_cnt != IMG_W*IMG_H-1.
  - Accepted beat with in_cnt==IMG_W*IMG_H-1 and up_tlast=0.
  - The frame continues in both cases; counting is authoritative.
- Simultaneous events:
  - ale_done in the same cycle as the last pass 1 beat sets ale_seen.
  - Final output beat in the same cycle as the last pass 2 input beat: go to DRAIN, exit on the next cycle.
  - Timeout expiry in the same cycle as ale_done: ale_done wins.

Decomposition:
- Package haze_ctrl_pkg: state enum (IDLE, ALE_PASS, ALE_WAIT, SRSC_PASS, DRAIN, DONE) and a pixel-count function.
- One sub-module, beat_counter: a counter with clear, increment and saturation, used for in_cnt, out_cnt and the timer.

Test Plan:
All scenarios use IMG_W=4, IMG_H=4, OUT_PIXELS=4, ALE_TIMEOUT=8, and core_s_tready=1 unless stated.
1. Nominal frame: start, skip_ale=0; 16 beats with tlast on beat 16; ale_done 3 cycles later; 16 beats; 4 core_m_tvalid -> haze_enable=0 throughout pass 1 and 1 in pass 2, up_tready=0 after each 16th beat, m_tlast on 4th output only, frame_done pulse, errors 0.
2. Second frame with skip_ale=1 after scenario 1 -> next edge enters SRSC_PASS, no pass 1, haze_enable=1 one cycle after start.
3. ALE timeout: no ale_done after 16 beats -> timeout_err=1 after 8 cycles, frame_done pulse, IDLE, a_valid stays unchanged; skip_ale then has no effect if never valid.
4. Backpressure: core_s_tready toggles 1010 and up_tvalid has gaps -> exactly 16 beats accepted per pass, core_s_tvalid never high while core_s_tready is gated by state.
5. Framing error: tlast on beat 5 -> tlast_err=1, frame still completes normally.
6. ARESETn asserted mid SRSC_PASS, then a new start -> all outputs 0 immediately; new frame runs pass 1, because a_valid was cleared by reset.
